ingress_frame_checker: RTL and testbench

Per-port ingress framing guard placed directly upstream of one port's push interface on the switch (`push`, `pushData`, `pushDataStartOfFrame`, `pushDataEndOfFrame`, `pushDataError`). It validates SOF/EOF sequencing and frame length, truncates or discards malformed frames, and forwards every accepted word with one cycle of registered latency. The switch push interface has no backpressure, so neither does this block.

---
 rtl/ingress_frame_checker.sv | 170 +++++++++++++++++
 tb/tb_ingress_frame_checker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ingress_frame_checker.sv
// ingress_frame_checker
//   Framing guard in front of one switch push port. Checks SOF/EOF
//   ordering and frame length, truncates oversize frames, terminates
//   frames interrupted by a nested SOF, and drops orphan words. Every
//   accepted word leaves one cycle later through registered outputs.
//   There is no backpressure in either direction.
//
//   Optional build macro: FRAME_CHECK_STATS_EN adds three 32-bit
//   statistics counters (goodFrames, badFrames, droppedWords) and
//   their ports. Without it the datapath is unchanged.
module ingress_frame_checker #(
  parameter int serialWidth   = 8,
  parameter int minFrameWords = 8,
  parameter int maxFrameWords = 1518,
  parameter int lenWidth      = $clog2(maxFrameWords + 1)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   inValid,
  input  logic [serialWidth-1:0] inData,
  input  logic                   inSof,
  input  logic                   inEof,
  input  logic                   inError,
  output logic                   push,
  output logic [serialWidth-1:0] pushData,
  output logic                   pushDataStartOfFrame,
  output logic                   pushDataEndOfFrame,
  output logic                   pushDataError
`ifdef FRAME_CHECK_STATS_EN
  ,
  output logic [31:0]            goodFrames,
  output logic [31:0]            badFrames,
  output logic [31:0]            droppedWords
`endif
);

  localparam logic [lenWidth-1:0] minLen = lenWidth'(minFrameWords);
  localparam logic [lenWidth-1:0] maxLen = lenWidth'(maxFrameWords);
  // A lone SOF+EOF word is a runt whenever frames must be longer than one word.
  localparam logic singleRunt = (minFrameWords > 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    DROP  = 2'd2
  } stateT;

  stateT               state;
  stateT               stateNext;
  logic [lenWidth-1:0] len;
  logic [lenWidth-1:0] lenNext;
  logic [lenWidth-1:0] lenInc;
  logic                err;
  logic                errNext;

  // Per-word decision, computed from the current input and pre-update state.
  logic                fwd;
  logic                sofOut;
  logic                eofOut;
  logic                errOut;

  assign lenInc = len + lenWidth'(1);

  // Next-state, length/error tracking and output-flag decode for the word on the input.
  always_comb begin
    stateNext = state;
    lenNext   = len;
    errNext   = err;
    fwd       = 1'b0;
    sofOut    = 1'b0;
    eofOut    = 1'b0;
    errOut    = 1'b0;

    if (inValid) begin
      case (state)
        FRAME: begin
          if (inSof) begin
            // Nested start: close the current frame as bad, discard the new one.
            fwd       = 1'b1;
            eofOut    = 1'b1;
            errOut    = 1'b1;
            stateNext = DROP;
          end else if (inEof) begin
            fwd       = 1'b1;
            eofOut    = 1'b1;
            errOut    = err | inError | (lenInc < minLen);
            lenNext   = lenInc;
            stateNext = IDLE;
          end else if (lenInc == maxLen) begin
            // Reached the limit without EOF: truncate here and drop the tail.
            fwd       = 1'b1;
            eofOut    = 1'b1;
            errOut    = 1'b1;
            lenNext   = lenInc;
            stateNext = DROP;
          end else begin
            fwd       = 1'b1;
            lenNext   = lenInc;
            errNext   = err | inError;
          end
        end

        default: begin
          // IDLE and DROP both accept a fresh SOF; DROP is how we recover.
          if (inSof) begin
            fwd    = 1'b1;
            sofOut = 1'b1;
            if (inEof) begin
              eofOut    = 1'b1;
              errOut    = inError | singleRunt;
              stateNext = IDLE;
            end else begin
              lenNext   = lenWidth'(1);
              errNext   = inError;
              stateNext = FRAME;
            end
          end else if ((state == DROP) && inEof) begin
            stateNext = IDLE;
          end
        end
      endcase
    end
  end

  // State, length counter and sticky error register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      len   <= '0;
      err   <= 1'b0;
    end else begin
      state <= stateNext;
      len   <= lenNext;
      err   <= errNext;
    end
  end

  // Output register stage: one cycle from input word to switch push.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      push                 <= 1'b0;
      pushData             <= '0;
      pushDataStartOfFrame <= 1'b0;
      pushDataEndOfFrame   <= 1'b0;
      pushDataError        <= 1'b0;
    end else begin
      push                 <= fwd;
      pushData             <= inData;
      pushDataStartOfFrame <= sofOut;
      pushDataEndOfFrame   <= eofOut;
      pushDataError        <= eofOut & errOut;
    end
  end

`ifdef FRAME_CHECK_STATS_EN
  // Statistics, updated on the same edge that presents the corresponding output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      goodFrames   <= '0;
      badFrames    <= '0;
      droppedWords <= '0;
    end else begin
      goodFrames   <= goodFrames   + 32'(fwd & eofOut & ~errOut);
      badFrames    <= badFrames    + 32'(fwd & eofOut & errOut);
      droppedWords <= droppedWords + 32'(inValid & ~fwd);
    end
  end
`endif

endmodule

// File: tb/tb_ingress_frame_checker.sv
// Directed bench for ingress_frame_checker (minFrameWords=8, maxFrameWords=16).
module tb_ingress_frame_checker;

  logic       clk = 1'b0;
  logic       rstn;
  logic       inValid;
  logic [7:0] inData;
  logic       inSof;
  logic       inEof;
  logic       inError;
  logic       push;
  logic [7:0] pushData;
  logic       pushDataStartOfFrame;
  logic       pushDataEndOfFrame;
  logic       pushDataError;
`ifdef FRAME_CHECK_STATS_EN
  logic [31:0] goodFrames;
  logic [31:0] badFrames;
  logic [31:0] droppedWords;
`endif

  int checks   = 0;
  int failures = 0;

  ingress_frame_checker #(
    .serialWidth  (8),
    .minFrameWords(8),
    .maxFrameWords(16)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .inValid             (inValid),
    .inData              (inData),
    .inSof               (inSof),
    .inEof               (inEof),
    .inError             (inError),
    .push                (push),
    .pushData            (pushData),
    .pushDataStartOfFrame(pushDataStartOfFrame),
    .pushDataEndOfFrame  (pushDataEndOfFrame),
    .pushDataError       (pushDataError)
`ifdef FRAME_CHECK_STATS_EN
    ,
    .goodFrames          (goodFrames),
    .badFrames           (badFrames),
    .droppedWords        (droppedWords)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Drive one input word, let it cross the edge, then check the registered output.
  task automatic step(input string tag, input logic v, input logic [7:0] d,
                      input logic s, input logic e, input logic er,
                      input logic ep, input logic es, input logic ee, input logic eer);
    inValid = v;
    inData  = d;
    inSof   = s;
    inEof   = e;
    inError = er;
    @(posedge clk);
    #1;
    chk({tag, ".push"}, {31'd0, push}, {31'd0, ep});
    if (ep) begin
      chk({tag, ".data"}, {24'd0, pushData}, {24'd0, d});
      chk({tag, ".sof"}, {31'd0, pushDataStartOfFrame}, {31'd0, es});
      chk({tag, ".eof"}, {31'd0, pushDataEndOfFrame}, {31'd0, ee});
      chk({tag, ".err"}, {31'd0, pushDataError}, {31'd0, eer});
    end
  endtask

  // Send an n-word frame (SOF on word 0, optional EOF on the last word, inError on
  // word errAt). expOut words are expected out, the last of them with EOF/expLastErr.
  task automatic frame(input string tag, input int n, input int errAt, input bit lastEof,
                       input int expOut, input bit expLastErr, input int base);
    for (int i = 0; i < n; i++) begin
      step($sformatf("%s[%0d]", tag, i), 1'b1, 8'(base + i),
           (i == 0), (lastEof && (i == n - 1)), (i == errAt),
           (i < expOut), (i == 0), (i == expOut - 1),
           (i == expOut - 1) ? expLastErr : 1'b0);
    end
    inValid = 1'b0;
  endtask

  task automatic chkStats(input string tag, input int g, input int b, input int dw);
`ifdef FRAME_CHECK_STATS_EN
    chk({tag, ".goodFrames"}, goodFrames, 32'(g));
    chk({tag, ".badFrames"}, badFrames, 32'(b));
    chk({tag, ".droppedWords"}, droppedWords, 32'(dw));
`else
    if (g < 0 || b < 0 || dw < 0) $display("negative stats expectation in %s", tag);
`endif
  endtask

  initial begin
    rstn    = 1'b0;
    inValid = 1'b0;
    inData  = 8'h00;
    inSof   = 1'b0;
    inEof   = 1'b0;
    inError = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.push", {31'd0, push}, 32'd0);
    chk("reset.data", {24'd0, pushData}, 32'd0);
    chk("reset.sof", {31'd0, pushDataStartOfFrame}, 32'd0);
    chk("reset.eof", {31'd0, pushDataEndOfFrame}, 32'd0);
    chk("reset.err", {31'd0, pushDataError}, 32'd0);
    chkStats("reset", 0, 0, 0);
    rstn = 1'b1;

    // Good 10-word frame, data 0x00..0x09.
    frame("good", 10, -1, 1'b1, 10, 1'b0, 0);
    chkStats("good", 1, 0, 0);

    // Runt of 5 words, then 9 words with inError on word 3.
    frame("runt", 5, -1, 1'b1, 5, 1'b1, 8'h20);
    frame("errw", 9, 2, 1'b1, 9, 1'b1, 8'h40);
    chkStats("runtErr", 1, 2, 0);

    // 20-word frame truncated at 16; words 17-20 dropped; next frame clean.
    frame("over", 20, -1, 1'b1, 16, 1'b1, 8'h60);
    chkStats("over", 1, 3, 4);
    frame("afterOver", 10, -1, 1'b1, 10, 1'b0, 8'h80);
    chkStats("afterOver", 2, 3, 4);

    // Orphan words while IDLE.
    for (int i = 0; i < 3; i++)
      step($sformatf("orphan[%0d]", i), 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0);
    chkStats("orphan", 2, 3, 7);

    // Nested SOF: 4 words, then SOF closes the frame with error; rest dropped.
    for (int i = 0; i < 4; i++)
      step($sformatf("nest[%0d]", i), 1'b1, 8'(8'hB0 + i), (i == 0), 1'b0, 1'b0,
           1'b1, (i == 0), 1'b0, 1'b0);
    step("nest[4]", 1'b1, 8'hB4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)
      step($sformatf("nestDrop[%0d]", i), 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0);
    step("nestEof", 1'b1, 8'hCF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chkStats("nest", 2, 4, 14);

    // Exactly maxFrameWords words ending in EOF is good.
    frame("exactMax", 16, -1, 1'b1, 16, 1'b0, 8'hD0);
    chkStats("exactMax", 3, 4, 14);

    // Single-word SOF+EOF is a runt.
    frame("single", 1, -1, 1'b1, 1, 1'b1, 8'h5A);
    chkStats("single", 3, 5, 14);

    // Truncate without EOF (stay in DROP), then a new SOF recovers cleanly.
    frame("trunc", 18, -1, 1'b0, 16, 1'b1, 8'h10);
    chkStats("trunc", 3, 6, 16);
    frame("recover", 8, -1, 1'b1, 8, 1'b0, 8'hE0);
    chkStats("recover", 4, 6, 16);

    // Reset after word 4 of a 10-word frame.
    for (int i = 0; i < 4; i++)
      step($sformatf("preRst[%0d]", i), 1'b1, 8'(8'h30 + i), (i == 0), 1'b0, 1'b0,
           1'b1, (i == 0), 1'b0, 1'b0);
    inValid = 1'b0;
    rstn    = 1'b0;
    #1;
    chk("midRst.push", {31'd0, push}, 32'd0);
    chk("midRst.data", {24'd0, pushData}, 32'd0);
    chk("midRst.sof", {31'd0, pushDataStartOfFrame}, 32'd0);
    chk("midRst.eof", {31'd0, pushDataEndOfFrame}, 32'd0);
    chkStats("midRst", 0, 0, 0);
    @(posedge clk);
    #1;
    chk("midRst.hold", {31'd0, push}, 32'd0);
    rstn = 1'b1;
    frame("postRst", 10, -1, 1'b1, 10, 1'b0, 8'h70);
    chkStats("postRst", 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
